sprite_draw_sequencer: RTL and testbench

SPRITE_DRAW_SEQUENCER -- requirements
Module: sprite_draw_sequencer

---
 rtl/sprite_draw_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_sprite_draw_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_draw_sequencer.sv
// Sprite draw sequencer: queues draw requests, runs one drawer at a time and
// re-aligns the drawer's coordinate stream with its one-cycle-late ROM colour.
module sprite_draw_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TIMEOUT       = 4095,
  parameter bit          TRANSP_EN     = 1'b1,
  parameter logic [2:0]  TRANSP_COLOUR = 3'b111
) (
  input  logic       clock_all,
  input  logic       reset_all,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_slot,
  input  logic [8:0] req_x,
  input  logic [7:0] req_y,
  output logic [1:0] drw_sel,
  output logic [8:0] drw_x,
  output logic [7:0] drw_y,
  output logic       drw_enable,
  output logic       drw_reset_n,
  input  logic       drw_done,
  input  logic [8:0] pix_x,
  input  logic [7:0] pix_y,
  input  logic [2:0] pix_colour,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic [11:0]   TO_LAST  = 12'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DRAW = 2'd2, S_DRAIN = 2'd3} state_e;

  typedef struct packed {
    logic [1:0] slot;
    logic [8:0] x;
    logic [7:0] y;
  } entry_t;

  entry_t          fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  state_e          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [8:0]      org_x_q, org_x_d, dx_q, dx_d;
  logic [7:0]      org_y_q, org_y_d, dy_q, dy_d;
  logic [11:0]     cyc_q, cyc_d;
  logic            dvalid_q, dvalid_d;
  logic            terr_q, terr_d;
  logic            fifo_empty_s, fifo_full_s, push_s, pop_s, timeout_s;
  entry_t          req_entry_s, head_s;

  assign fifo_empty_s = (count_q == '0);
  assign fifo_full_s  = (count_q == FULL_CNT);
  assign req_ready    = !fifo_full_s && !reset_all;
  assign push_s       = req_valid && req_ready;
  assign req_entry_s  = entry_t'({req_slot, req_x, req_y});
  // An empty FIFO lets a request accepted in IDLE/DRAIN go straight to LOAD.
  assign head_s       = fifo_empty_s ? req_entry_s : fifo_mem_q[rd_ptr_q];

  // State register plus all datapath registers.
  always_ff @(posedge clock_all or posedge reset_all) begin
    if (reset_all) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sel_q    <= 2'b00;
      org_x_q  <= 9'd0;
      org_y_q  <= 8'd0;
      cyc_q    <= 12'd0;
      dvalid_q <= 1'b0;
      dx_q     <= 9'd0;
      dy_q     <= 8'd0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sel_q    <= sel_d;
      org_x_q  <= org_x_d;
      org_y_q  <= org_y_d;
      cyc_q    <= cyc_d;
      dvalid_q <= dvalid_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      terr_q   <= terr_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clock_all) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= req_entry_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    timeout_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty_s || push_s) state_d = S_LOAD;
        else                         state_d = S_IDLE;
      end
      S_LOAD: state_d = S_DRAW;
      S_DRAW: begin
        if (drw_done) begin
          state_d = S_DRAIN;
        end else if (cyc_q == TO_LAST) begin
          state_d   = S_DRAIN;
          timeout_s = 1'b1;
        end else begin
          state_d = S_DRAW;
        end
      end
      S_DRAIN: begin
        if (!fifo_empty_s || push_s) state_d = S_LOAD;
        else                         state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs to the drawer.
  always_comb begin
    drw_enable  = 1'b0;
    drw_reset_n = 1'b0;
    case (state_q)
      S_DRAW: begin
        drw_enable  = 1'b1;
        drw_reset_n = 1'b1;
      end
      default: begin
        drw_enable  = 1'b0;
        drw_reset_n = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping, drawer load, cycle counter and pixel delay stage.
  always_comb begin
    pop_s    = (state_d == S_LOAD);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    else        wr_ptr_d = wr_ptr_q;
    if (pop_s)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
    else        rd_ptr_d = rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    sel_d   = pop_s ? head_s.slot : sel_q;
    org_x_d = pop_s ? head_s.x    : org_x_q;
    org_y_d = pop_s ? head_s.y    : org_y_q;
    if (state_q == S_LOAD)      cyc_d = 12'd0;
    else if (state_q == S_DRAW) cyc_d = cyc_q + 12'd1;
    else                        cyc_d = cyc_q;
    // An aborted draw drops the pixel captured on its last cycle.
    dvalid_d = (state_q == S_DRAW) && !timeout_s;
    dx_d     = (state_q == S_DRAW) ? pix_x : dx_q;
    dy_d     = (state_q == S_DRAW) ? pix_y : dy_q;
    terr_d   = terr_q || timeout_s;
  end

  assign drw_sel     = sel_q;
  assign drw_x       = org_x_q;
  assign drw_y       = org_y_q;
  assign vga_x       = dx_q;
  assign vga_y       = dy_q;
  assign vga_colour  = dvalid_q ? pix_colour : 3'b000;
  assign vga_plot    = dvalid_q && !(TRANSP_EN && (pix_colour == TRANSP_COLOUR));
  assign busy        = (state_q != S_IDLE) || !fifo_empty_s;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Bench for sprite_draw_sequencer: drawer model with registered colour ROM,
// a table of single-draw vectors and hand-written multi-cycle sequences.
module tb_sprite_draw_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_slot = 2'd0;
  logic [8:0] req_x = 9'd0;
  logic [7:0] req_y = 8'd0;
  logic [1:0] drw_sel;
  logic [8:0] drw_x;
  logic [7:0] drw_y;
  logic       drw_enable, drw_reset_n, drw_done;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic [2:0] pix_colour = 3'b000;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, timeout_err;

  sprite_draw_sequencer dut (
    .clock_all(clk), .reset_all(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_slot(req_slot), .req_x(req_x), .req_y(req_y),
    .drw_sel(drw_sel), .drw_x(drw_x), .drw_y(drw_y),
    .drw_enable(drw_enable), .drw_reset_n(drw_reset_n), .drw_done(drw_done),
    .pix_x(pix_x), .pix_y(pix_y), .pix_colour(pix_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic int w_of(input logic [1:0] s);
    case (s)
      2'd0: return 53;
      2'd1: return 4;
      2'd2: return 10;
      default: return 1;
    endcase
  endfunction

  function automatic int h_of(input logic [1:0] s);
    case (s)
      2'd0: return 57;
      2'd1: return 3;
      2'd2: return 2;
      default: return 1;
    endcase
  endfunction

  bit transp_mode = 1'b0;
  bit hang_slot0  = 1'b0;

  function automatic logic [2:0] colour_of(input int n, input bit t);
    if (t && (n % 10 == 9)) return 3'b111;
    return 3'(n % 7);
  endfunction

  // Drawer model: counter cleared by drw_reset_n, colour ROM one cycle late.
  int m_cnt = 0;
  always @(posedge clk) begin
    if (!drw_reset_n)    m_cnt <= 0;
    else if (drw_enable) m_cnt <= m_cnt + 1;
    pix_colour <= colour_of(m_cnt, transp_mode);
  end
  assign pix_x    = 9'(int'(drw_x) + m_cnt % w_of(drw_sel));
  assign pix_y    = 8'(int'(drw_y) + m_cnt / w_of(drw_sel));
  assign drw_done = drw_enable && (m_cnt == w_of(drw_sel) * h_of(drw_sel) - 1)
                    && !(hang_slot0 && drw_sel == 2'd0);

  int nplots, fx, fy, lx, ly, pair_err, en_cycles, runs, gap, max_gap;
  bit en_prev = 1'b0;
  bit chk_pair = 1'b0;
  int cur_ox, cur_oy, cur_w;
  int starts[$];

  always @(negedge clk) begin
    if (vga_plot) begin
      if (nplots == 0) begin
        fx = int'(vga_x);
        fy = int'(vga_y);
      end
      lx = int'(vga_x);
      ly = int'(vga_y);
      nplots++;
      if (chk_pair && vga_colour != colour_of((int'(vga_x) - cur_ox) + (int'(vga_y) - cur_oy) * cur_w, transp_mode))
        pair_err++;
    end
    if (drw_enable) en_cycles++;
    if (drw_enable && !en_prev) begin
      if (runs > 0 && gap > max_gap) max_gap = gap;
      starts.push_back(int'(drw_x));
      runs++;
      gap = 0;
    end else if (!drw_enable) begin
      gap++;
    end
    en_prev = drw_enable;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else            n_pass++;
  endtask

  task automatic clear_stats();
    nplots = 0; fx = -1; fy = -1; lx = -1; ly = -1; pair_err = 0;
    en_cycles = 0; runs = 0; gap = 0; max_gap = 0;
    starts.delete();
  endtask

  task automatic send(input logic [1:0] s, input logic [8:0] x, input logic [7:0] y);
    int n = 0;
    req_valid = 1'b1; req_slot = s; req_x = x; req_y = y;
    while (!req_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    check("accept", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  typedef struct {
    logic [1:0] slot;
    logic [8:0] x;
    logic [7:0] y;
    bit         transp;
    int         plots;
    int         fx, fy, lx, ly;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'd0, 9'd100, 8'd50,  1'b0, 3021, 100, 50,  152, 106};
    vecs[1] = '{2'd1, 9'd0,   8'd0,   1'b0, 12,   0,   0,   3,   2};
    vecs[2] = '{2'd2, 9'd500, 8'd250, 1'b1, 18,   500, 250, 508, 251};
    vecs[3] = '{2'd3, 9'd511, 8'd255, 1'b1, 1,    511, 255, 511, 255};
    vecs[4] = '{2'd1, 9'd7,   8'd9,   1'b1, 11,   7,   9,   10,  11};
    vecs[5] = '{2'd0, 9'd100, 8'd50,  1'b1, 2719, 100, 50,  152, 106};
    clear_stats();

    // Reset values while reset is held.
    #1 rst = 1'b1;
    #2;
    check("rst_vga_plot",  int'(vga_plot), 0);
    check("rst_vga_x",     int'(vga_x), 0);
    check("rst_drw_en",    int'(drw_enable), 0);
    check("rst_drw_rstn",  int'(drw_reset_n), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_terr",      int'(timeout_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", int'(req_ready), 1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      transp_mode = vecs[i].transp;
      cur_ox = int'(vecs[i].x);
      cur_oy = int'(vecs[i].y);
      cur_w  = w_of(vecs[i].slot);
      chk_pair = 1'b1;
      clear_stats();
      send(vecs[i].slot, vecs[i].x, vecs[i].y);
      wait_idle(20000);
      check($sformatf("v%0d_plots", i),  nplots, vecs[i].plots);
      check($sformatf("v%0d_first_x", i), fx, vecs[i].fx);
      check($sformatf("v%0d_first_y", i), fy, vecs[i].fy);
      check($sformatf("v%0d_last_x", i),  lx, vecs[i].lx);
      check($sformatf("v%0d_last_y", i),  ly, vecs[i].ly);
      check($sformatf("v%0d_pairing", i), pair_err, 0);
      check($sformatf("v%0d_draw_cycles", i), en_cycles, w_of(vecs[i].slot) * h_of(vecs[i].slot));
    end
    chk_pair = 1'b0;
    transp_mode = 1'b0;

    // Latency: LOAD the cycle after accept, first plot two cycles after LOAD.
    clear_stats();
    send(2'd3, 9'd5, 8'd6);
    check("lat_load_sel",  int'(drw_sel), 3);
    check("lat_load_x",    int'(drw_x), 5);
    check("lat_load_y",    int'(drw_y), 6);
    check("lat_load_en",   int'(drw_enable), 0);
    check("lat_load_busy", int'(busy), 1);
    @(negedge clk);
    check("lat_draw_en",   int'(drw_enable), 1);
    check("lat_draw_rstn", int'(drw_reset_n), 1);
    check("lat_draw_plot", int'(vga_plot), 0);
    @(negedge clk);
    check("lat_drain_plot", int'(vga_plot), 1);
    check("lat_drain_x",    int'(vga_x), 5);
    check("lat_drain_y",    int'(vga_y), 6);
    check("lat_drain_en",   int'(drw_enable), 0);
    @(negedge clk);
    check("lat_idle_busy",  int'(busy), 0);
    check("lat_idle_plot",  int'(vga_plot), 0);

    // Back-to-back: one draw running plus four queued fills the FIFO.
    clear_stats();
    for (int i = 0; i < 5; i++) send(2'd1, 9'(10 * (i + 1)), 8'd0);
    check("b2b_ready_full", int'(req_ready), 0);
    send(2'd1, 9'd60, 8'd0);
    check("b2b_ready_refull", int'(req_ready), 0);
    wait_idle(2000);
    check("b2b_runs",    runs, 6);
    check("b2b_plots",   nplots, 72);
    check("b2b_max_gap", max_gap, 2);
    check("b2b_order_n", starts.size(), 6);
    for (int i = 0; i < starts.size() && i < 6; i++)
      check($sformatf("b2b_order%0d", i), starts[i], 10 * (i + 1));

    // Timeout with drw_done stuck low, then a normal queued draw.
    clear_stats();
    hang_slot0 = 1'b1;
    check("to_terr_before", int'(timeout_err), 0);
    send(2'd0, 9'd0, 8'd0);
    send(2'd3, 9'd200, 8'd100);
    wait_idle(6000);
    hang_slot0 = 1'b0;
    check("to_terr_after",   int'(timeout_err), 1);
    check("to_draw_cycles",  en_cycles, 4096);
    check("to_plots",        nplots, 4095);
    check("to_runs",         runs, 2);
    check("to_next_x",       lx, 200);
    check("to_next_y",       ly, 100);

    // Reset pulsed mid-draw with a request still queued.
    clear_stats();
    send(2'd0, 9'd100, 8'd50);
    send(2'd1, 9'd0, 8'd0);
    for (int n = 0; n < 10 && !drw_enable; n++) @(negedge clk);
    repeat (499) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_plot",   int'(vga_plot), 0);
    check("mid_rst_vga_x",  int'(vga_x), 0);
    check("mid_rst_vga_y",  int'(vga_y), 0);
    check("mid_rst_colour", int'(vga_colour), 0);
    check("mid_rst_en",     int'(drw_enable), 0);
    check("mid_rst_rstn",   int'(drw_reset_n), 0);
    check("mid_rst_sel",    int'(drw_sel), 0);
    check("mid_rst_drw_x",  int'(drw_x), 0);
    check("mid_rst_drw_y",  int'(drw_y), 0);
    check("mid_rst_busy",   int'(busy), 0);
    check("mid_rst_ready",  int'(req_ready), 0);
    check("mid_rst_terr",   int'(timeout_err), 0);
    clear_stats();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_plots", nplots, 0);
    check("post_rst_runs",  runs, 0);
    check("post_rst_busy",  int'(busy), 0);
    send(2'd3, 9'd1, 8'd2);
    wait_idle(100);
    check("post_rst_new_plots", nplots, 1);
    check("post_rst_new_x",     lx, 1);
    check("post_rst_new_y",     ly, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
